// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the ROB-side trap sequencer and its CSR-unit peer.
// Holds the state encoding, exception cause codes and the datapath widths.
package trap_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PCW    = 30;
    localparam int unsigned CAUSEW = 5;

    typedef logic [2:0] trap_state_t;

    localparam trap_state_t ST_IDLE  = 3'd0;
    localparam trap_state_t ST_FLUSH = 3'd1;
    localparam trap_state_t ST_CSR   = 3'd2;
    localparam trap_state_t ST_REDIR = 3'd3;
    localparam trap_state_t ST_DRAIN = 3'd4;

    // Cause codes must stay in step with the CSR unit's mcause decode.
    localparam logic [CAUSEW-1:0] ECAUSE_INSN_MISALIGNED  = 5'd0;
    localparam logic [CAUSEW-1:0] ECAUSE_INSN_ACCESS      = 5'd1;
    localparam logic [CAUSEW-1:0] ECAUSE_ILLEGAL_INSN     = 5'd2;
    localparam logic [CAUSEW-1:0] ECAUSE_BREAKPOINT       = 5'd3;
    localparam logic [CAUSEW-1:0] ECAUSE_LOAD_MISALIGNED  = 5'd4;
    localparam logic [CAUSEW-1:0] ECAUSE_LOAD_ACCESS      = 5'd5;
    localparam logic [CAUSEW-1:0] ECAUSE_STORE_MISALIGNED = 5'd6;
    localparam logic [CAUSEW-1:0] ECAUSE_STORE_ACCESS     = 5'd7;
    localparam logic [CAUSEW-1:0] ECAUSE_ECALL_U          = 5'd8;
    localparam logic [CAUSEW-1:0] ECAUSE_ECALL_S          = 5'd9;
    localparam logic [CAUSEW-1:0] ECAUSE_ECALL_M          = 5'd11;

endpackage

// File: rtl/trap_drain_ctr.sv
// 4-bit loadable down-counter with zero flag; times the post-redirect drain.
// Decrement saturates at zero so an overlong dec request cannot wrap.
module trap_drain_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 4'd0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != 4'd0)) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign zero = (count_q == 4'd0);

endmodule

// File: rtl/trap_ctrl.sv
// ROB-side trap sequencer: flush, hand exception record to CSR, redirect fetch, drain.
// All strobes decode from the state register; only redirect_addr is a gated tvec mux.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              head_valid,
    input  logic              head_error,
    input  logic [CAUSEW-1:0] head_ecause,
    input  logic [PCW-1:0]    head_addr,
    input  logic [XLEN-1:0]   head_tval,
    output logic              rob_flush,
    output logic              rob_csr_valid,
    output logic [PCW-1:0]    rob_csr_epc,
    output logic [CAUSEW-1:0] rob_csr_ecause,
    output logic [XLEN-1:0]   rob_csr_tval,
    input  logic [PCW-1:0]    csr_tvec,
    output logic              redirect_valid,
    output logic [PCW-1:0]    redirect_addr,
    output logic              trap_busy
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    trap_state_t       state_q, state_d;
    logic [PCW-1:0]    epc_q;
    logic [CAUSEW-1:0] cause_q;
    logic [XLEN-1:0]   tval_q;
    logic              drain_zero;
    logic              take_trap;

    // head_* only matter in IDLE; later heads belong to flushed instructions.
    assign take_trap = (state_q == ST_IDLE) && head_valid && head_error;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (take_trap) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_CSR;
            ST_CSR:   state_d = ST_REDIR;
            ST_REDIR: state_d = ST_DRAIN;
            ST_DRAIN: if (drain_zero) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take_trap) begin
                epc_q   <= head_addr;
                cause_q <= head_ecause;
                tval_q  <= head_tval;
            end
        end
    end

    trap_drain_ctr u_drain_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == ST_REDIR),
        .load_val (DRAIN_LOAD),
        .dec      (state_q == ST_DRAIN),
        .zero     (drain_zero)
    );

    assign rob_flush      = (state_q == ST_FLUSH);
    assign rob_csr_valid  = (state_q == ST_CSR);
    assign redirect_valid = (state_q == ST_REDIR);
    assign trap_busy      = (state_q != ST_IDLE);
    assign rob_csr_epc    = epc_q;
    assign rob_csr_ecause = cause_q;
    assign rob_csr_tval   = tval_q;
    // tvec is read a cycle after the CSR strobe, so any mtvec write has landed.
    assign redirect_addr  = (state_q == ST_REDIR) ? csr_tvec : '0;

endmodule
